// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg: SHA-256 round constants, IV, round helper functions, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Full 32-byte reversal: byte 0 (LSB) of the input becomes the output MSB.
  function automatic logic [255:0] byte_rev(input logic [255:0] x);
    logic [255:0] r;
    for (int b = 0; b < 32; b++) begin
      r[8*b +: 8] = x[255-8*b -: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// ============================================================================
// sha256_round: one combinational SHA-256 round, packed {a,b,c,d,e,f,g,h}
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = bsig0(a) + maj(a, b, c);

  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

`default_nettype wire

// File: rtl/sha256_compress_core.sv
// ============================================================================
// sha256_compress_core: SHA-256 compression, RPC rounds per clock, sliding W window
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_i,
  input  logic [255:0] chain_i,
  input  logic         use_iv,
  input  logic         swap_out,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest_o
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_rpc_check
    $fatal(1, "sha256_compress_core: RPC must be 1, 2, 4 or 8");
  end

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [31:0]  win_q [16];
  logic [31:0]  win_d [16];
  logic [255:0] hin_q, hin_d;
  logic [255:0] work_q, work_d;
  logic [255:0] digest_q, digest_d;
  logic         swap_q, swap_d;
  logic         done_q, done_d;

  logic [31:0]  ext [16+RPC];
  logic [255:0] rounds_out;
  logic [255:0] sum;

  // ext[j] is W for round cnt+j; ext[16..] extends the window by RPC new words.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = win_q[i];
    end
    for (int j = 0; j < RPC; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
  end

  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    if (j == 0) begin : g_first
      assign st_in = work_q;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
    end
    sha256_round u_round (
      .state_i (st_in),
      .k_i     (K[cnt_q + 6'(j)]),
      .w_i     (ext[j]),
      .state_o (st_out)
    );
  end

  assign rounds_out = g_rnd[RPC-1].st_out;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum[32*i +: 32] = hin_q[32*i +: 32] + work_q[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hin_d    = hin_q;
    work_d   = work_q;
    swap_d   = swap_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = block_i[511-32*i -: 32];
          end
          hin_d   = use_iv ? IV : chain_i;
          work_d  = use_iv ? IV : chain_i;
          swap_d  = swap_out;
          cnt_d   = 6'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        for (int i = 0; i < 16; i++) begin
          win_d[i] = ext[i+RPC];
        end
        work_d = rounds_out;
        cnt_d  = cnt_q + 6'(RPC);
        if (cnt_q == 6'(64 - RPC)) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        digest_d = swap_q ? byte_rev(sum) : sum;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      hin_q    <= '0;
      work_q   <= '0;
      digest_q <= '0;
      swap_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hin_q    <= hin_d;
      work_q   <= work_d;
      digest_q <= digest_d;
      swap_q   <= swap_d;
      done_q   <= done_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = ~ready;
  assign done     = done_q;
  assign digest_o = digest_q;

endmodule

`default_nettype wire
